// File: rtl/fc_pkg.sv
// Shared FC layer package: sequencer state encoding and the layer dimensions
// also used by the MAC array and the weight ROM.
package fc_pkg;
    localparam int FC_NUM_INPUTS  = 507;
    localparam int FC_NUM_NEURONS = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_BIAS  = 2'd2,
        ST_DONE  = 2'd3
    } fc_state_t;
endpackage

// File: rtl/fc_address_sequencer_if.sv
// Control and address bus of the FC address sequencer.
// FCSEQ_BIAS_BEAT_EN adds the bias_beat flag.
interface fc_address_sequencer_if #(
    parameter int ADDR_W  = 10,
    parameter int WADDR_W = 13,
    parameter int NEUR_W  = 4
);
    logic               start;
    logic               abort;
    logic               out_ready;
    logic               addr_valid;
    logic [ADDR_W-1:0]  act_addr;
    logic [WADDR_W-1:0] wgt_addr;
    logic [NEUR_W-1:0]  neuron_idx;
    logic               first;
    logic               last;
    logic               busy;
    logic               done;
`ifdef FCSEQ_BIAS_BEAT_EN
    logic               bias_beat;

    modport master (input start, abort, out_ready,
                    output addr_valid, act_addr, wgt_addr, neuron_idx,
                    output first, last, busy, done, bias_beat);
    modport slave  (output start, abort, out_ready,
                    input addr_valid, act_addr, wgt_addr, neuron_idx,
                    input first, last, busy, done, bias_beat);
`else
    modport master (input start, abort, out_ready,
                    output addr_valid, act_addr, wgt_addr, neuron_idx,
                    output first, last, busy, done);
    modport slave  (output start, abort, out_ready,
                    input addr_valid, act_addr, wgt_addr, neuron_idx,
                    input first, last, busy, done);
`endif
endinterface

// File: rtl/fc_wrap_counter.sv
// Modulo-MAX up counter with synchronous clear; wrap flags the terminal count.
module fc_wrap_counter #(
    parameter int MAX   = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);
    logic [WIDTH-1:0] count_q, count_d;

    assign wrap  = (count_q == WIDTH'(MAX - 1));
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (en)
            count_d = wrap ? '0 : count_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end
endmodule

// File: rtl/fc_address_sequencer.sv
// Sequences activation / weight addresses for every FC output neuron.
// FCSEQ_BIAS_BEAT_EN inserts one bias beat after each neuron.
module fc_address_sequencer
    import fc_pkg::*;
#(
    parameter int NUM_INPUTS  = FC_NUM_INPUTS,
    parameter int NUM_NEURONS = FC_NUM_NEURONS,
    parameter int ADDR_W      = 10,
    parameter int WADDR_W     = 13,
    parameter int NEUR_W      = 4
) (
    input logic                    clk,
    input logic                    rst,
    fc_address_sequencer_if.master bus
);
`ifdef FCSEQ_BIAS_BEAT_EN
    localparam int WGT_SPAN = NUM_NEURONS * (NUM_INPUTS + 1);
`else
    localparam int WGT_SPAN = NUM_NEURONS * NUM_INPUTS;
`endif
    localparam logic [WADDR_W-1:0] BIAS_BASE = WADDR_W'(NUM_NEURONS * NUM_INPUTS);

    if (NUM_INPUTS < 1 || NUM_NEURONS < 1) begin : g_bad_dims
        $fatal(1, "fc_address_sequencer: NUM_INPUTS and NUM_NEURONS must be >= 1");
    end
    if ((2 ** ADDR_W) < NUM_INPUTS) begin : g_bad_addr_w
        $fatal(1, "fc_address_sequencer: ADDR_W too small for NUM_INPUTS");
    end
    if ((2 ** NEUR_W) < NUM_NEURONS) begin : g_bad_neur_w
        $fatal(1, "fc_address_sequencer: NEUR_W too small for NUM_NEURONS");
    end
    if ((2 ** WADDR_W) < WGT_SPAN) begin : g_bad_waddr_w
        $fatal(1, "fc_address_sequencer: WADDR_W too small for weight span");
    end

    fc_state_t          state_q, state_d;
    logic [WADDR_W-1:0] wgt_q, wgt_d;
    logic [ADDR_W-1:0]  pos;
    logic [NEUR_W-1:0]  neuron;
    logic               pos_wrap, neur_wrap;
    logic               sweep, bias, beat, pos_en, neur_en, cnt_clr;

    assign sweep = (state_q == ST_SWEEP);
`ifdef FCSEQ_BIAS_BEAT_EN
    assign bias    = (state_q == ST_BIAS);
    assign neur_en = beat & bias;
`else
    assign bias    = 1'b0;
    assign neur_en = pos_en & pos_wrap;
`endif
    assign beat    = (sweep | bias) & bus.out_ready;
    assign pos_en  = beat & sweep;
    // Counters sit at zero outside a pass so a fresh start always begins at 0.
    assign cnt_clr = bus.abort | (state_q == ST_IDLE) | (state_q == ST_DONE);

    fc_wrap_counter #(.MAX(NUM_INPUTS), .WIDTH(ADDR_W)) u_pos_cnt (
        .clk(clk), .rst(rst), .en(pos_en), .clr(cnt_clr),
        .count(pos), .wrap(pos_wrap)
    );

    fc_wrap_counter #(.MAX(NUM_NEURONS), .WIDTH(NEUR_W)) u_neur_cnt (
        .clk(clk), .rst(rst), .en(neur_en), .clr(cnt_clr),
        .count(neuron), .wrap(neur_wrap)
    );

    always_comb begin
        state_d = state_q;
        wgt_d   = wgt_q;
        case (state_q)
            ST_IDLE:  if (bus.start) state_d = ST_SWEEP;
            ST_SWEEP: if (beat) begin
                wgt_d = wgt_q + 1'b1;
                if (pos_wrap) begin
`ifdef FCSEQ_BIAS_BEAT_EN
                    state_d = ST_BIAS;
`else
                    state_d = neur_wrap ? ST_DONE : ST_SWEEP;
`endif
                end
            end
            ST_BIAS:  if (beat) state_d = neur_wrap ? ST_DONE : ST_SWEEP;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (bus.abort || state_q == ST_DONE) wgt_d = '0;
        if (bus.abort) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wgt_q   <= '0;
        end else begin
            state_q <= state_d;
            wgt_q   <= wgt_d;
        end
    end

    // Outputs decode registered state only, so they hold while out_ready is low.
    assign bus.addr_valid = sweep | bias;
    assign bus.act_addr   = pos;
    assign bus.wgt_addr   = bias ? BIAS_BASE + WADDR_W'(neuron) : wgt_q;
    assign bus.neuron_idx = neuron;
    assign bus.first      = sweep & (pos == '0);
    assign bus.last       = sweep & pos_wrap;
    assign bus.busy       = sweep | bias;
    assign bus.done       = (state_q == ST_DONE);
`ifdef FCSEQ_BIAS_BEAT_EN
    assign bus.bias_beat  = bias;
`endif
endmodule

// File: tb/tb_fc_address_sequencer.sv
// Directed bench for fc_address_sequencer (4x3 main instance, 1x1 corner instance).
module tb_fc_address_sequencer;
    localparam int NI = 4, NN = 3, AW = 3, WW = 5, NW = 2;

    typedef struct {
        int act;
        int wgt;
        int neur;
        int first;
        int last;
        int bias;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fc_address_sequencer_if #(.ADDR_W(AW), .WADDR_W(WW), .NEUR_W(NW)) bus ();
    fc_address_sequencer #(.NUM_INPUTS(NI), .NUM_NEURONS(NN), .ADDR_W(AW),
                           .WADDR_W(WW), .NEUR_W(NW))
        dut (.clk(clk), .rst(rst), .bus(bus));

    fc_address_sequencer_if #(.ADDR_W(1), .WADDR_W(2), .NEUR_W(1)) bus1 ();
    fc_address_sequencer #(.NUM_INPUTS(1), .NUM_NEURONS(1), .ADDR_W(1),
                           .WADDR_W(2), .NEUR_W(1))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int    errs = 0;
    int    checks = 0;
    beat_t exp_q[$];

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, int'(bus.addr_valid), 0);
        chk({tag, "_act"},   int'(bus.act_addr), 0);
        chk({tag, "_wgt"},   int'(bus.wgt_addr), 0);
        chk({tag, "_neur"},  int'(bus.neuron_idx), 0);
        chk({tag, "_first"}, int'(bus.first), 0);
        chk({tag, "_last"},  int'(bus.last), 0);
        chk({tag, "_busy"},  int'(bus.busy), 0);
        chk({tag, "_done"},  int'(bus.done), 0);
    endtask

    task automatic chk_beat(input int k);
        beat_t e;
        e = exp_q[k];
        chk($sformatf("b%0d_valid", k), int'(bus.addr_valid), 1);
        chk($sformatf("b%0d_busy", k),  int'(bus.busy), 1);
        chk($sformatf("b%0d_act", k),   int'(bus.act_addr), e.act);
        chk($sformatf("b%0d_wgt", k),   int'(bus.wgt_addr), e.wgt);
        chk($sformatf("b%0d_neur", k),  int'(bus.neuron_idx), e.neur);
        chk($sformatf("b%0d_first", k), int'(bus.first), e.first);
        chk($sformatf("b%0d_last", k),  int'(bus.last), e.last);
`ifdef FCSEQ_BIAS_BEAT_EN
        chk($sformatf("b%0d_bias", k),  int'(bus.bias_beat), e.bias);
`endif
    endtask

    // Issues start, then walks the pass; optional start/abort/reset injection at a beat index.
    task automatic run_pass(input bit rnd, input int start_at, input int abort_at, input int rst_at);
        int k, cyc;
        bit fin;
        k = 0;
        fin = 1'b0;
        bus.start = 1'b1;
        step;
        bus.start = 1'b0;
        for (cyc = 0; cyc < 200; cyc++) begin
            bus.out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.start = (k == start_at);
            bus.abort = (k == abort_at);
            if (bus.done) begin
                fin = 1'b1;
                break;
            end
            if (k >= exp_q.size()) begin
                chk("overrun", k, exp_q.size() - 1);
                break;
            end
            chk_beat(k);
            if (k == rst_at) begin
                #3 rst = 1'b1;
                #1 chk_idle("async_rst");
                bus.start = 1'b0;
                bus.abort = 1'b0;
                step;
                rst = 1'b0;
                return;
            end
            if (k == abort_at) begin
                step;
                bus.abort = 1'b0;
                bus.start = 1'b0;
                chk_idle("abort");
                step;
                chk("abort_nodone", int'(bus.done), 0);
                return;
            end
            if (bus.addr_valid && bus.out_ready) k++;
            step;
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("pass_finished", int'(fin), 1);
        chk("beats", k, exp_q.size());
        if (!rnd) chk("done_cycle", cyc, exp_q.size());
        chk("done_pulse", int'(bus.done), 1);
        chk("done_busy", int'(bus.busy), 0);
        chk("done_valid", int'(bus.addr_valid), 0);
        step;
        chk("done_drop", int'(bus.done), 0);
        chk("idle_busy", int'(bus.busy), 0);
    endtask

    initial begin
        beat_t b;
        bus.start = 1'b0; bus.abort = 1'b0; bus.out_ready = 1'b1;
        bus1.start = 1'b0; bus1.abort = 1'b0; bus1.out_ready = 1'b1;

        for (int n = 0; n < NN; n++) begin
            for (int p = 0; p < NI; p++) begin
                b.act = p; b.wgt = n * NI + p; b.neur = n;
                b.first = (p == 0); b.last = (p == NI - 1); b.bias = 0;
                exp_q.push_back(b);
            end
`ifdef FCSEQ_BIAS_BEAT_EN
            b.act = 0; b.wgt = NN * NI + n; b.neur = n;
            b.first = 0; b.last = 0; b.bias = 1;
            exp_q.push_back(b);
`endif
        end

        #12 chk_idle("rst_held");
        step;
        rst = 1'b0;
        step;
        chk_idle("rst_rel");

        run_pass(1'b0, -1, -1, -1);
        step;
        run_pass(1'b1, -1, -1, -1);
        step;
        run_pass(1'b0, 5, 6, -1);
        step;
        run_pass(1'b0, -1, -1, -1);
        step;
        run_pass(1'b0, -1, -1, 9);
        for (int i = 0; i < 3; i++) begin
            step;
            chk("rst_nodone", int'(bus.done), 0);
        end
        chk_idle("rst_after");

        bus1.start = 1'b1;
        step;
        bus1.start = 1'b0;
        chk("s1_valid", int'(bus1.addr_valid), 1);
        chk("s1_first", int'(bus1.first), 1);
        chk("s1_last",  int'(bus1.last), 1);
        chk("s1_wgt",   int'(bus1.wgt_addr), 0);
        chk("s1_act",   int'(bus1.act_addr), 0);
`ifdef FCSEQ_BIAS_BEAT_EN
        step;
        chk("s1_bias",      int'(bus1.bias_beat), 1);
        chk("s1_bias_wgt",  int'(bus1.wgt_addr), 1);
        chk("s1_bias_last", int'(bus1.last), 0);
`endif
        step;
        chk("s1_done", int'(bus1.done), 1);
        chk("s1_busy", int'(bus1.busy), 0);
        step;
        chk("s1_done_drop", int'(bus1.done), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
